// File: rtl/sum_accumulator_pkg.sv
// Shared types for the frame sum accumulator.
`default_nettype none

package sum_accumulator_pkg;

   typedef enum logic [0:0] {
      ACCUM = 1'b0,
      HOLD  = 1'b1
   } state_t;

endpackage

`default_nettype wire

// File: rtl/sum_accumulator_adder.sv
// Unsigned adder: X = A + B with the carry in X[DATA_WIDTH].
`default_nettype none

module sum_accumulator_adder #(
   parameter int DATA_WIDTH = 4
) (
   input  logic [DATA_WIDTH-1:0] A,
   input  logic [DATA_WIDTH-1:0] B,
   output logic [DATA_WIDTH:0]   X
);

   assign X = {1'b0, A} + {1'b0, B};

endmodule

`default_nettype wire

// File: rtl/sum_accumulator.sv
// Accumulates a frame of unsigned words and holds the total, word count and
// overflow flag until the downstream side accepts them.
`default_nettype none

module sum_accumulator
   import sum_accumulator_pkg::*;
#(
   parameter int DATA_WIDTH = 4,
   parameter int ACC_WIDTH  = 12,
   parameter int CNT_WIDTH  = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH:0]   in_data,
   input  logic                  in_last,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [ACC_WIDTH-1:0]  out_sum,
   output logic [CNT_WIDTH-1:0]  out_count,
   output logic                  out_overflow
);

   state_t               state;
   state_t               state_next;
   logic [ACC_WIDTH-1:0] acc;
   logic [CNT_WIDTH-1:0] count;
   logic                 overflow;
   logic [ACC_WIDTH-1:0] data_ext;
   logic [ACC_WIDTH:0]   sum_x;
   logic                 take;
   logic                 give;

   always_comb begin
      data_ext = '0;
      data_ext[DATA_WIDTH:0] = in_data;
   end

   sum_accumulator_adder #(
      .DATA_WIDTH (ACC_WIDTH)
   ) u_adder (
      .A (acc),
      .B (data_ext),
      .X (sum_x)
   );

   // Handshake qualifiers depend only on registered state, never on the
   // partner's valid/ready, so there is no combinational loop across the ports.
   assign in_ready  = (state == ACCUM);
   assign out_valid = (state == HOLD);
   assign take      = in_valid && in_ready;
   assign give      = out_valid && out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ACCUM;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         ACCUM:   if (in_valid && in_last) state_next = HOLD;
         HOLD:    if (out_ready)           state_next = ACCUM;
         default:                          state_next = ACCUM;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc      <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else if (give) begin
         acc      <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else if (take) begin
         acc      <= sum_x[ACC_WIDTH-1:0];
         overflow <= overflow | sum_x[ACC_WIDTH];
         if (count != '1) begin
            count <= count + 1'b1;
         end
      end
   end

   assign out_sum      = acc;
   assign out_count    = count;
   assign out_overflow = overflow;

endmodule

`default_nettype wire

// File: tb/tb_sum_accumulator.sv
// Self-checking bench for sum_accumulator against a frame-level arithmetic model.
`default_nettype none

module tb_sum_accumulator;

   localparam int DW = 4;
   localparam int AW = 12;
   localparam int CW = 8;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_last = 1'b0;
   logic          out_ready = 1'b0;
   logic [DW:0]   in_data = '0;
   logic          in_ready;
   logic          out_valid;
   logic [AW-1:0] out_sum;
   logic [CW-1:0] out_count;
   logic          out_overflow;

   int checks = 0;
   int failures = 0;

   sum_accumulator #(
      .DATA_WIDTH (DW),
      .ACC_WIDTH  (AW),
      .CNT_WIDTH  (CW)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_data      (in_data),
      .in_last      (in_last),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_sum      (out_sum),
      .out_count    (out_count),
      .out_overflow (out_overflow)
   );

   always #5 clk = ~clk;

   // Frame result from plain arithmetic on the list of words.
   function automatic void ref_frame(input int words[$], output int s, output int c, output int o);
      longint total = 0;
      foreach (words[i]) total += words[i];
      s = int'(total % (64'd1 << AW));
      c = (words.size() > (1 << CW) - 1) ? (1 << CW) - 1 : words.size();
      o = (total > (64'd1 << AW) - 1) ? 1 : 0;
   endfunction

   // Enters and leaves at posedge+1.
   task automatic send_word(input int data, input bit last, input int gap);
      int waited = 0;
      in_valid = 1'b0;
      repeat (gap) begin @(posedge clk); #1; end
      in_valid = 1'b1;
      in_data  = (DW+1)'(data);
      in_last  = last;
      @(negedge clk);
      while (!in_ready && waited < 50) begin waited++; @(negedge clk); end
      if (!in_ready) begin
         checks++; failures++;
         $display("FAIL send_timeout in_ready=%0b required=1", in_ready);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   // Observes one result (no checking) and completes the output handshake.
   task automatic collect(input int stall, output bit got, output int lat,
                          output int s, output int c, output int o);
      got = 0; lat = -1; s = 0; c = 0; o = 0;
      for (int i = 0; i < 50 && !got; i++) begin
         @(negedge clk);
         if (out_valid) begin got = 1; lat = i; end
      end
      if (got) begin
         s = out_sum; c = out_count; o = out_overflow;
         repeat (stall) @(negedge clk);
         out_ready = 1'b1;
      end
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic send_frame(input int words[$], input int max_gap);
      foreach (words[i])
         send_word(words[i], i == words.size() - 1, (max_gap > 0) ? $urandom_range(max_gap, 0) : 0);
   endtask

   task automatic check_frame(input string name, input int words[$], input int stall, input bit check_lat);
      bit got; int lat, s, c, o, es, ec, eo;
      ref_frame(words, es, ec, eo);
      collect(stall, got, lat, s, c, o);
      checks++;
      if (!got) begin
         failures++; $display("FAIL %s_valid out_valid never rose", name);
      end else begin
         if (check_lat) begin
            checks++;
            if (lat !== 0) begin failures++; $display("FAIL %s_latency got=%0d required=0", name, lat); end
         end
         checks++;
         if (s !== es) begin failures++; $display("FAIL %s_sum got=%0d required=%0d", name, s, es); end
         checks++;
         if (c !== ec) begin failures++; $display("FAIL %s_count got=%0d required=%0d", name, c, ec); end
         checks++;
         if (o !== eo) begin failures++; $display("FAIL %s_overflow got=%0d required=%0d", name, o, eo); end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0b required=0", out_valid); end
      checks++;
      if (out_sum !== '0 || out_count !== '0 || out_overflow !== 1'b0) begin
         failures++;
         $display("FAIL reset_regs got=%0d/%0d/%0b required=0/0/0", out_sum, out_count, out_overflow);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%0b required=1", in_ready); end
      @(posedge clk); #1;
   endtask

   task automatic test_basic();
      send_frame('{3, 5, 7}, 0);
      check_frame("basic", '{3, 5, 7}, 0, 1);
      send_frame('{31}, 0);
      check_frame("single", '{31}, 0, 1);
   endtask

   task automatic test_overflow();
      int words[$];
      for (int i = 0; i < 133; i++) words.push_back(31);
      send_frame(words, 0);
      check_frame("ovf133", words, 0, 1);
      words.delete();
      for (int i = 0; i < 260; i++) words.push_back(31);
      send_frame(words, 0);
      check_frame("saturate", words, 2, 1);
   endtask

   task automatic test_stall();
      send_frame('{10, 20}, 0);
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1;
         in_data  = (DW+1)'($urandom_range(31, 0));
         in_last  = 1'(i & 1);
         @(negedge clk);
         checks++;
         if (out_valid !== 1'b1 || out_sum !== 30 || out_count !== 2 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL stall_hold cyc=%0d valid=%0b sum=%0d count=%0d in_ready=%0b required=1/30/2/0",
                     i, out_valid, out_sum, out_count, in_ready);
         end
         @(posedge clk); #1;
      end
      in_valid  = 1'b0;
      in_last   = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         failures++; $display("FAIL stall_release in_ready=%0b out_valid=%0b required=1/0", in_ready, out_valid);
      end
      checks++;
      if (out_sum !== 0 || out_count !== 0 || out_overflow !== 1'b0) begin
         failures++; $display("FAIL stall_cleared got=%0d/%0d/%0b required=0/0/0", out_sum, out_count, out_overflow);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid();
      send_word(9, 0, 0);
      send_word(9, 0, 0);
      rst_n = 1'b0;
      @(negedge clk);
      checks++;
      if (out_sum !== 0 || out_count !== 0 || out_valid !== 1'b0) begin
         failures++; $display("FAIL midreset_clear got=%0d/%0d/%0b required=0/0/0", out_sum, out_count, out_valid);
      end
      @(posedge clk);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin failures++; $display("FAIL midreset_no_result got=%0b required=0", out_valid); end
      @(posedge clk); #1;
      send_frame('{1}, 0);
      check_frame("midreset", '{1}, 0, 1);
   endtask

   task automatic test_back_to_back();
      int data_q[3] = '{2, 2, 4};
      bit last_q[3] = '{0, 1, 1};
      int rs[2], rc[2];
      int es, ec, eo, idx = 0, nres = 0, notready = 0;
      bit xfer;
      in_valid  = 1'b1;
      in_data   = (DW+1)'(data_q[0]);
      in_last   = last_q[0];
      out_ready = 1'b1;
      for (int cyc = 0; cyc < 8; cyc++) begin
         @(negedge clk);
         if (!in_ready) notready++;
         if (out_valid && nres < 2) begin rs[nres] = out_sum; rc[nres] = out_count; nres++; end
         xfer = in_ready && in_valid;
         @(posedge clk); #1;
         if (xfer) begin
            idx++;
            if (idx < 3) begin
               in_data = (DW+1)'(data_q[idx]);
               in_last = last_q[idx];
            end else begin
               in_valid = 1'b0;
               in_last  = 1'b0;
            end
         end
      end
      out_ready = 1'b0;
      checks++;
      if (nres !== 2) begin
         failures++; $display("FAIL b2b_results got=%0d required=2", nres);
      end else begin
         ref_frame('{2, 2}, es, ec, eo);
         checks++;
         if (rs[0] !== es || rc[0] !== ec) begin
            failures++; $display("FAIL b2b_frame0 got=%0d/%0d required=%0d/%0d", rs[0], rc[0], es, ec);
         end
         ref_frame('{4}, es, ec, eo);
         checks++;
         if (rs[1] !== es || rc[1] !== ec) begin
            failures++; $display("FAIL b2b_frame1 got=%0d/%0d required=%0d/%0d", rs[1], rc[1], es, ec);
         end
      end
      checks++;
      if (notready !== 2) begin failures++; $display("FAIL b2b_idle got=%0d required=2", notready); end
   endtask

   task automatic test_random();
      int words[$];
      for (int f = 0; f < 25; f++) begin
         words.delete();
         for (int i = 0, n = $urandom_range(12, 1); i < n; i++) words.push_back($urandom_range(31, 0));
         send_frame(words, 2);
         check_frame($sformatf("rand%0d", f), words, $urandom_range(3, 0), 1);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_overflow();
      test_stall();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
